ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//   Serial boot loader sitting directly upstream of the 16K x 16 data RAM.
//   Consumes a byte stream from the UART receiver, checks a length/checksum frame,
//   assembles big-endian 16-bit words and writes them into RAM from address 0.
//   Drives the RAM's in_value/load/address ports; status outputs gate CPU start.
// PARAMETERS
//   ADDR_W          14      RAM address width; max frame length = 2**ADDR_W words
//   TIMEOUT_CYCLES  100000  idle cycles mid-frame before abort; 0 disables timeout
// PORTS
//   clk           in   1       system clock, all logic on posedge
//   reset         in   1       synchronous, active-high
//   rx_data       in   8       received byte
//   rx_valid      in   1       1-cycle strobe, rx_data valid; may assert every cycle
//   ram_in        out  16      word to RAM in_value
//   ram_load      out  1       RAM write enable, 1-cycle pulse per word
//   ram_address   out  ADDR_W  RAM address
//   busy          out  1       frame in progress (states LEN_LO..CHECK)
//   done          out  1       frame loaded and checksum matched (sticky)
//   error         out  1       frame aborted (sticky)
//   words_written out  ADDR_W+1 count of RAM writes issued this frame
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, checksum 0, write pointer 0, timeout counter 0.
//   Frame: LEN_HI LEN_LO {D_HI D_LO} x LEN CSUM; LEN is big-endian 16-bit word count.
//   No backpressure: every rx_valid byte is consumed in the cycle it is presented.
//   All outputs registered; every state transition happens on the rx_valid edge.
//   FSM:
//   - IDLE:   rx_valid -> len[15:8]=byte, sum=byte, -> LEN_LO.
//   - LEN_LO: rx_valid -> len[7:0]=byte; if LEN==0 -> CHECK;
//             if LEN > 2**ADDR_W -> ERROR (no RAM writes); else -> D_HI.
//   - D_HI:   rx_valid -> hold byte as high half -> D_LO.
//   - D_LO:   rx_valid -> next edge: ram_in={hi,byte}, ram_address=ptr, ram_load=1;
//             ptr and words_written +1; -> CHECK when words_written reaches LEN, else D_HI.
//   - CHECK:  rx_valid -> byte==sum ? DONE : ERROR.
//   - DONE/ERROR: terminal; rx_valid ignored; only reset leaves them.
//   sum: 8-bit wrap-around add of every byte from LEN_HI through last D_LO.
//   Write pulse lasts exactly one cycle; ram_address and ram_in hold their last
//     written values between writes (RAM reads that address; harmless).
//   ptr never wraps: LEN limit guarantees max ptr = 2**ADDR_W-1.
//   Timeout: counter clears on each accepted byte and runs only in LEN_LO, D_HI, D_LO, CHECK;
//     error rises exactly TIMEOUT_CYCLES edges after the edge accepting the last byte.
//   Bad checksum or timeout: RAM words already written stay written; error only flags it.
//   done and error never both 1; busy=0 in IDLE, DONE, ERROR.
//   Reset mid-frame: next edge returns to IDLE; any pending write pulse is dropped.
// TESTING
//   1. Reset, idle 20 cycles -> all outputs 0, no ram_load.
//   2. Bytes 00 02 12 34 AB CD C0 -> writes 0x1234@0, 0xABCD@1, done=1, words_written=2.
//   3. As 2 but checksum C1 -> same two writes, error=1, done=0.
//   4. Bytes 00 00 00 -> done=1, zero ram_load pulses; 40 01 -> error after 2nd byte, no writes.
//   5. TIMEOUT_CYCLES=100; bytes 00 02 12 then silence -> error rises 100 cycles after 12.
//   6. Frame 2 streamed back-to-back, one byte per cycle -> same writes as 2; reset mid-D_LO -> IDLE, no write.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: serial boot loader framing a byte stream into big-endian RAM word writes
module ram_loader #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, LEN_LO, D_HI, D_LO, CHECK, DONE, ERROR} state_t;
    state_t state, state_n;
    logic [15:0]       len;
    logic [15:0]       len_full;
    logic [7:0]        sum;
    logic [7:0]        hi;
    logic [ADDR_W-1:0] ptr;
    logic [TW-1:0]     tcnt;
    logic              in_frame;
    logic              in_frame_n;
    logic              last_word;
    logic              timed_out;
    assign len_full   = {len[15:8], rx_data};
    assign in_frame   = state inside {LEN_LO, D_HI, D_LO, CHECK};
    assign in_frame_n = state_n inside {LEN_LO, D_HI, D_LO, CHECK};
    assign last_word  = 32'(words_written) + 32'd1 == 32'(len);
    assign timed_out  = (TIMEOUT_CYCLES != 0) && in_frame && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // next-state: every transition is taken on an accepted byte, except the idle timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rx_valid) state_n = LEN_LO;
            LEN_LO:  if (rx_valid) state_n = (len_full == 16'd0) ? CHECK :
                                             (32'(len_full) > (32'd1 << ADDR_W)) ? ERROR : D_HI;
            D_HI:    if (rx_valid) state_n = D_LO;
            D_LO:    if (rx_valid) state_n = last_word ? CHECK : D_HI;
            CHECK:   if (rx_valid) state_n = (rx_data == sum) ? DONE : ERROR;
            default: state_n = state;
        endcase
        if (timed_out) state_n = ERROR;
    end
    // datapath: length/checksum capture, word assembly, RAM write and registered status
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_in        <= '0;
            ram_load      <= 1'b0;
            ram_address   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            len           <= '0;
            sum           <= '0;
            hi            <= '0;
            ptr           <= '0;
            tcnt          <= '0;
        end else begin
            ram_load <= 1'b0;
            busy     <= in_frame_n;
            done     <= state_n == DONE;
            error    <= state_n == ERROR;
            tcnt     <= (rx_valid || !in_frame) ? '0 : tcnt + 1'b1;
            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        len[15:8] <= rx_data;
                        sum       <= rx_data;
                    end
                    LEN_LO: begin
                        len[7:0] <= rx_data;
                        sum      <= sum + rx_data;
                    end
                    D_HI: begin
                        hi  <= rx_data;
                        sum <= sum + rx_data;
                    end
                    D_LO: begin
                        ram_in        <= {hi, rx_data};
                        ram_address   <= ptr;
                        ram_load      <= 1'b1;
                        ptr           <= ptr + 1'b1;
                        words_written <= words_written + 1'b1;
                        sum           <= sum + rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader framing, checksum, timeout and reset
module tb_ram_loader;
    localparam int ADDR_W = 14;
    localparam int TMO    = 100;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [15:0]       ram_in;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_address;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_written;
    int checks = 0;
    int failures = 0;
    logic [ADDR_W+15:0] exp_q[$];
    logic [ADDR_W+15:0] exp_w;
    ram_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .busy(busy), .done(done), .error(error), .words_written(words_written)
    );
    always #5 clk = ~clk;
    // scoreboard: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (ram_load) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h", ram_address, ram_in);
            end else begin
                exp_w = exp_q.pop_front();
                if ({ram_address, ram_in} !== exp_w) begin
                    failures++;
                    $display("FAIL write got=%h/%h want=%h/%h", ram_address, ram_in,
                             exp_w[ADDR_W+15:16], exp_w[15:0]);
                end
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask
    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        if (gap > 0) tick(gap);
    endtask
    task automatic check_status(input string name, input logic d, input logic e, input logic b,
                                input logic [ADDR_W:0] ww);
        checks++;
        if ({done, error, busy, words_written} !== {d, e, b, ww}) begin
            failures++;
            $display("FAIL %s done/error/busy/ww got=%b/%b/%b/%0d want=%b/%b/%b/%0d",
                     name, done, error, busy, words_written, d, e, b, ww);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got=%0d pending want=0", name, exp_q.size());
        end
    endtask
    task automatic test_reset();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if ({ram_in, ram_load, ram_address, busy, done, error, words_written} !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_outputs got=%0d nonzero cycles want=0", bad);
        end
        check_status("reset", 1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic frame2(input logic [7:0] csum, input int gap);
        exp_q.push_back({14'd0, 16'h1234});
        exp_q.push_back({14'd1, 16'hABCD});
        send(8'h00, gap);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_frame got=%b want=1", busy);
        end
        send(8'h02, gap);
        send(8'h12, gap);
        send(8'h34, gap);
        send(8'hAB, gap);
        send(8'hCD, gap);
        send(csum, gap);
        tick(2);
        checks++;
        if ({ram_address, ram_in} !== {14'd1, 16'hABCD}) begin
            failures++;
            $display("FAIL hold_last got=%h/%h want=0001/abcd", ram_address, ram_in);
        end
    endtask
    task automatic test_good_frame();
        do_reset();
        frame2(8'hC0, 3);
        check_status("good_frame", 1'b1, 1'b0, 1'b0, 15'd2);
    endtask
    task automatic test_bad_checksum();
        do_reset();
        frame2(8'hC1, 3);
        check_status("bad_csum", 1'b0, 1'b1, 1'b0, 15'd2);
    endtask
    task automatic test_lengths();
        do_reset();
        send(8'h00, 2);
        send(8'h00, 2);
        send(8'h00, 2);
        check_status("len_zero", 1'b1, 1'b0, 1'b0, '0);
        do_reset();
        send(8'h40, 2);
        send(8'h01, 0);
        checks++;
        if ({error, done, busy} !== 3'b100) begin
            failures++;
            $display("FAIL len_over error/done/busy got=%b%b%b want=100", error, done, busy);
        end
        tick(5);
        check_status("len_over", 1'b0, 1'b1, 1'b0, '0);
    endtask
    task automatic test_timeout();
        do_reset();
        exp_q.push_back({14'd0, 16'h1234});
        send(8'h00, 1);
        send(8'h02, 1);
        send(8'h12, 0);
        tick(TMO - 1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early error/busy got=%b/%b want=0/1", error, busy);
        end
        tick(1);
        exp_q.delete();
        check_status("timeout", 1'b0, 1'b1, 1'b0, '0);
    endtask
    task automatic test_back_to_back();
        do_reset();
        frame2(8'hC0, 0);
        check_status("b2b", 1'b1, 1'b0, 1'b0, 15'd2);
        do_reset();
        exp_q.push_back({14'd0, 16'h1234});
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'hAB, 0);
        rx_data = 8'hCD;
        rx_valid = 1'b1;
        reset = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        reset = 1'b0;
        tick(3);
        check_status("mid_reset", 1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back({14'd0, 16'h00EE});
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hEE, 0);
        send(8'hEF, 0);
        tick(2);
        check_status("after_reset", 1'b1, 1'b0, 1'b0, 15'd1);
    endtask
    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_lengths();
        test_timeout();
        test_back_to_back();
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
